gate_bist_checker: RTL and testbench

Synthesizable self-test engine for the 2-input gates in the gates library; it is the checking side of the gate interface. It drives A/B through all four input vectors and holds each one for a programmable settle time. It then samples the gate's X output and compares it against a parameterized truth table, reporting a per-vector fail mask and an overall pass flag. It sits beside any 2-input gate under test, including the delayed variants, and replaces hand-read `$display` checking.

---
 rtl/gate_bist_checker_pkg.sv | 21 ++
 rtl/gate_bist_checker_settle_timer.sv | 36 +++
 rtl/gate_bist_checker.sv | 121 ++++++++++++
 tb/tb_gate_bist_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_checker_pkg.sv
// Shared definitions for the 2-input gate self-test engine: FSM state
// encodings, timer width and the truth tables of the standard gates, indexed by {B,A}.
package gate_bist_checker_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } bist_state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_checker_settle_timer.sv
// Loadable down-counter that measures how long each test vector settles.
// It stops at zero, so it cannot underflow while it waits for the FSM.
module settle_timer
  import gate_bist_checker_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_value_i,
  input  logic               enable_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test engine for a 2-input gate. It walks {B,A} through 00,01,10,11 and holds
// each vector for SETTLE_CYCLES+1 cycles. It then checks X against EXPECT and reports the result.
module gate_bist_checker
  import gate_bist_checker_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 10,
  parameter logic [3:0] EXPECT        = TT_AND
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       x_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] fail_mask_o
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

  bist_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic [3:0]  mask_q, mask_d;
  logic        pass_q, pass_d;
  logic        timer_load;
  logic        timer_expired;
  logic        mismatch;
  logic [1:0]  idx_next;

  settle_timer u_timer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_i       (timer_load),
    .load_value_i (RELOAD),
    .enable_i     (state_q == ST_SETTLE),
    .expired_o    (timer_expired)
  );

  // Case equality makes an X or Z on the gate output count as a mismatch in simulation.
  assign mismatch = (x_i === EXPECT[idx_q]) ? 1'b0 : 1'b1;
  assign idx_next = idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    mask_d     = mask_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start_i) begin
          state_d    = ST_SETTLE;
          idx_d      = 2'd0;
          mask_d     = 4'b0000;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        mask_d[idx_q] = mismatch;
        if (idx_q == 2'd3) begin
          state_d = ST_REPORT;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (mask_d == 4'b0000);
        end else begin
          state_d    = ST_SETTLE;
          idx_d      = idx_next;
          a_d        = idx_next[0];
          b_d        = idx_next[1];
          timer_load = 1'b1;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      mask_q  <= 4'b0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done_o      = (state_q == ST_REPORT);
  assign pass_o      = pass_q;
  assign fail_mask_o = mask_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker. It drives zero-delay, delayed, OR and XOR gate
// models beside four checker instances and compares their outputs with hand-computed values.
module tb_gate_bist_checker;
  import gate_bist_checker_pkg::*;

  localparam int S10 = 10;
  localparam int S20 = 20;
  localparam int S1  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start10, x10, a10, b10, busy10, done10, pass10;
  logic start20, x20, a20, b20, busy20, done20, pass20;
  logic startOr, xOr, aOr, bOr, busyOr, doneOr, passOr;
  logic start1, x1, a1, b1, busy1, done1, pass1;
  logic [3:0] mask10, mask20, maskOr, mask1;

  int gateSel;
  logic [14:0] delay10 = '0;
  logic [14:0] delay20 = '0;
  int doneCount10 = 0;
  int checkCount = 0;
  int errorCount = 0;
  int dc;

  gate_bist_checker #(.SETTLE_CYCLES(S10), .EXPECT(TT_AND)) dut10 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start10), .x_i(x10), .a_o(a10), .b_o(b10),
    .busy_o(busy10), .done_o(done10), .pass_o(pass10), .fail_mask_o(mask10));

  gate_bist_checker #(.SETTLE_CYCLES(S20), .EXPECT(TT_AND)) dut20 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start20), .x_i(x20), .a_o(a20), .b_o(b20),
    .busy_o(busy20), .done_o(done20), .pass_o(pass20), .fail_mask_o(mask20));

  gate_bist_checker #(.SETTLE_CYCLES(S10), .EXPECT(TT_OR)) dutOr (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(startOr), .x_i(xOr), .a_o(aOr), .b_o(bOr),
    .busy_o(busyOr), .done_o(doneOr), .pass_o(passOr), .fail_mask_o(maskOr));

  gate_bist_checker #(.SETTLE_CYCLES(S1), .EXPECT(TT_XOR)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .x_i(x1), .a_o(a1), .b_o(b1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_mask_o(mask1));

  // Gate models: selectable AND / 15-cycle-delayed AND / OR for dut10, delayed AND for dut20.
  always @(posedge clk) begin
    delay10 <= {delay10[13:0], a10 & b10};
    delay20 <= {delay20[13:0], a20 & b20};
    if (done10) doneCount10 <= doneCount10 + 1;
  end

  always_comb begin
    x10 = a10 & b10;
    if (gateSel == 1) x10 = delay10[14];
    else if (gateSel == 2) x10 = a10 | b10;
  end

  assign x20 = delay20[14];
  assign xOr = aOr | bOr;
  assign x1  = a1 ^ b1;

  initial begin
    assert (S10 >= 1 && S10 <= 255) else $fatal(1, "[TB] illegal SETTLE_CYCLES %0d", S10);
    assert (S20 >= 1 && S20 <= 255) else $fatal(1, "[TB] illegal SETTLE_CYCLES %0d", S20);
    assert (S1 >= 1 && S1 <= 255) else $fatal(1, "[TB] illegal SETTLE_CYCLES %0d", S1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulses START for one edge on the selected instance and returns just after edge 0.
  task automatic applyStimulus(input int which);
    @(negedge clk);
    case (which)
      0: start10 = 1'b1;
      1: start20 = 1'b1;
      2: startOr = 1'b1;
      default: start1 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start10 = 1'b0;
    start20 = 1'b0;
    startOr = 1'b0;
    start1  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start10 = 1'b0; start20 = 1'b0; startOr = 1'b0; start1 = 1'b0;
    gateSel = 0;
    #22;
    checkOutput("reset_ab", {30'd0, b10, a10}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy10}, 32'd0);
    checkOutput("reset_done", {31'd0, done10}, 32'd0);
    checkOutput("reset_pass", {31'd0, pass10}, 32'd0);
    checkOutput("reset_mask", {28'd0, mask10}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-delay AND: vectors change every 11 edges, DONE after edge 44.
    applyStimulus(0);
    checkOutput("and_v0_ab", {30'd0, b10, a10}, 32'd0);
    checkOutput("and_v0_busy", {31'd0, busy10}, 32'd1);
    waitEdges(10);
    checkOutput("and_v0_hold", {30'd0, b10, a10}, 32'd0);
    waitEdges(1);
    checkOutput("and_v1_ab", {30'd0, b10, a10}, 32'd1);
    waitEdges(11);
    checkOutput("and_v2_ab", {30'd0, b10, a10}, 32'd2);
    waitEdges(11);
    checkOutput("and_v3_ab", {30'd0, b10, a10}, 32'd3);
    waitEdges(10);
    checkOutput("and_e43_done", {31'd0, done10}, 32'd0);
    checkOutput("and_e43_busy", {31'd0, busy10}, 32'd1);
    waitEdges(1);
    checkOutput("and_done", {31'd0, done10}, 32'd1);
    checkOutput("and_report_busy", {31'd0, busy10}, 32'd0);
    checkOutput("and_report_ab", {30'd0, b10, a10}, 32'd0);
    checkOutput("and_pass", {31'd0, pass10}, 32'd1);
    checkOutput("and_mask", {28'd0, mask10}, 32'd0);
    waitEdges(1);
    checkOutput("and_done_one_cycle", {31'd0, done10}, 32'd0);
    checkOutput("and_pass_held", {31'd0, pass10}, 32'd1);

    // 15-cycle delayed AND: the 11 sample still sees the stale 10 result.
    gateSel = 1;
    waitEdges(20);
    applyStimulus(0);
    checkOutput("dly_start_clears_pass", {31'd0, pass10}, 32'd0);
    waitEdges(44);
    checkOutput("dly_done", {31'd0, done10}, 32'd1);
    checkOutput("dly_mask", {28'd0, mask10}, 32'd8);
    checkOutput("dly_pass", {31'd0, pass10}, 32'd0);

    applyStimulus(1);
    waitEdges(83);
    checkOutput("dly20_e83_done", {31'd0, done20}, 32'd0);
    waitEdges(1);
    checkOutput("dly20_done", {31'd0, done20}, 32'd1);
    checkOutput("dly20_pass", {31'd0, pass20}, 32'd1);
    checkOutput("dly20_mask", {28'd0, mask20}, 32'd0);

    // OR gate against an AND table, then against an OR table.
    gateSel = 2;
    waitEdges(3);
    applyStimulus(0);
    waitEdges(44);
    checkOutput("or_vs_and_mask", {28'd0, mask10}, 32'd6);
    checkOutput("or_vs_and_pass", {31'd0, pass10}, 32'd0);
    applyStimulus(2);
    waitEdges(44);
    checkOutput("or_vs_or_done", {31'd0, doneOr}, 32'd1);
    checkOutput("or_vs_or_pass", {31'd0, passOr}, 32'd1);
    checkOutput("or_vs_or_mask", {28'd0, maskOr}, 32'd0);

    // Reset in the middle of vector 2 aborts the run without a DONE.
    gateSel = 0;
    waitEdges(3);
    applyStimulus(0);
    waitEdges(25);
    checkOutput("pre_abort_ab", {30'd0, b10, a10}, 32'd2);
    dc = doneCount10;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ab", {30'd0, b10, a10}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy10}, 32'd0);
    checkOutput("abort_done", {31'd0, done10}, 32'd0);
    waitEdges(2);
    @(negedge clk);
    rst_n = 1'b1;
    waitEdges(50);
    checkOutput("abort_no_done", dc, doneCount10);
    applyStimulus(0);
    waitEdges(44);
    checkOutput("after_abort_done", {31'd0, done10}, 32'd1);
    checkOutput("after_abort_pass", {31'd0, pass10}, 32'd1);

    // START while busy and during REPORT is ignored.
    waitEdges(3);
    dc = doneCount10;
    applyStimulus(0);
    waitEdges(5);
    applyStimulus(0);
    waitEdges(38);
    checkOutput("ignore_done_e44", {31'd0, done10}, 32'd1);
    applyStimulus(0);
    waitEdges(3);
    checkOutput("ignore_report_busy", {31'd0, busy10}, 32'd0);
    waitEdges(50);
    checkOutput("ignore_single_done", doneCount10 - dc, 32'd1);

    // START held high: DONE after edges 44 and 90 (45 quiet cycles in between).
    dc = doneCount10;
    @(negedge clk);
    start10 = 1'b1;
    @(posedge clk);
    #1;
    waitEdges(44);
    checkOutput("b2b_done1", {31'd0, done10}, 32'd1);
    waitEdges(45);
    checkOutput("b2b_gap", {31'd0, done10}, 32'd0);
    waitEdges(1);
    checkOutput("b2b_done2", {31'd0, done10}, 32'd1);
    @(negedge clk);
    start10 = 1'b0;
    waitEdges(60);
    checkOutput("b2b_two_runs", doneCount10 - dc, 32'd2);

    // SETTLE_CYCLES=1 with XOR: two-cycle hold, DONE after edge 8.
    applyStimulus(3);
    checkOutput("s1_v0_ab", {30'd0, b1, a1}, 32'd0);
    waitEdges(2);
    checkOutput("s1_v1_ab", {30'd0, b1, a1}, 32'd1);
    waitEdges(5);
    checkOutput("s1_e7_done", {31'd0, done1}, 32'd0);
    waitEdges(1);
    checkOutput("s1_done", {31'd0, done1}, 32'd1);
    checkOutput("s1_pass", {31'd0, pass1}, 32'd1);
    checkOutput("s1_mask", {28'd0, mask1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
